digit_serial_addsub: RTL and testbench

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

---
 rtl/digit_serial_pkg.sv | 16 +
 rtl/addsub_digit.sv | 40 ++++
 rtl/digit_serial_addsub.sv | 151 +++++++++++++++
 tb/tb_digit_serial_addsub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e  : controller states (idle, running through digits, result ready)
//   MODE_SUB : mode value selecting x - y - bin
//   MODE_ADD : mode value selecting x + y + bin
package digit_serial_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple add/subtract slice.
//   a, b  : operand digits
//   cin   : carry-in (add) or borrow-in (subtract)
//   mode  : MODE_ADD or MODE_SUB
//   d     : sum/difference digit
//   cout  : carry/borrow out of the top bit of the digit
//   ctop  : carry/borrow into the top bit of the digit (used for overflow)
module addsub_digit
  import digit_serial_pkg::*;
#(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [DIGIT-1:0] d,
  output logic             cout,
  output logic             ctop
);

  always_comb begin
    logic [DIGIT:0] c;
    c    = '0;
    d    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = a[i] ^ b[i] ^ c[i];
      if (mode == MODE_ADD) begin
        c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end else begin
        // Borrow out: a < b, or a == b with an incoming borrow.
        c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
      end
    end
    cout = c[DIGIT];
    ctop = c[DIGIT-1];
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor. Processes DIGIT bits per cycle, LSB digit
// first, with the carry/borrow registered between digits.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : begin an operation (accepted in idle or done state)
//   mode     : 0 = x - y - bin, 1 = x + y + bin
//   x, y     : operands
//   bin      : carry-in / borrow-in
//   busy     : operation in progress
//   done     : one-cycle pulse, result valid
//   result   : sum or difference
//   bout     : carry/borrow out of the MSB
//   overflow : two's-complement overflow
module digit_serial_addsub
  import digit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             overflow
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : gen_param_err
    $error("digit_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               mode_q, mode_d;
  logic               cy_q, cy_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               last_dig;
  logic [DIGIT-1:0]   dig_a, dig_b, dig_d;
  logic               dig_cout, dig_ctop;

  assign accept   = start && (state_q != StRun);
  assign last_dig = (cnt_q == CNT_W'(NDIG - 1));
  assign dig_a    = x_q[cnt_q*DIGIT +: DIGIT];
  assign dig_b    = y_q[cnt_q*DIGIT +: DIGIT];

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (cy_q),
    .mode (mode_q),
    .d    (dig_d),
    .cout (dig_cout),
    .ctop (dig_ctop)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_dig) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy     = (state_q == StRun);
    done     = (state_q == StDone);
    result   = result_q;
    bout     = bout_q;
    overflow = ovf_q;
  end

  // Datapath next-state.
  always_comb begin
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    cy_d     = cy_q;
    result_d = result_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      x_d    = x;
      y_d    = y;
      mode_d = mode;
      cy_d   = bin;
      cnt_d  = '0;
    end else if (state_q == StRun) begin
      result_d[cnt_q*DIGIT +: DIGIT] = dig_d;
      cy_d  = dig_cout;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_dig) begin
        bout_d = dig_cout;
        ovf_d  = dig_cout ^ dig_ctop;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 1'b0;
      cy_q     <= 1'b0;
      result_q <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      cy_q     <= cy_d;
      result_q <= result_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (DIGIT = 4, 1, 16) share the
// operand inputs and have private start lines. Expected results are queued
// when an operation is accepted and compared when done pulses.
module tb_digit_serial_addsub;

  typedef struct {
    logic [15:0] res;
    logic        bo;
    logic        ov;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode;
  logic [15:0] x, y;
  logic        bin;
  logic [2:0]  start_v;
  logic [2:0]  busy_v, done_v, bout_v, ovf_v;
  logic [15:0] res_v [3];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .mode(mode), .x(x), .y(y),
    .bin(bin), .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]),
    .bout(bout_v[0]), .overflow(ovf_v[0])
  );
  digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .mode(mode), .x(x), .y(y),
    .bin(bin), .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]),
    .bout(bout_v[1]), .overflow(ovf_v[1])
  );
  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .mode(mode), .x(x), .y(y),
    .bin(bin), .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]),
    .bout(bout_v[2]), .overflow(ovf_v[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ndig(input int w);
    case (w)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  // Reference: full-width arithmetic; MSB carry/borrow-in from the low 15 bits.
  function automatic exp_t model(input logic m, input logic [15:0] a, input logic [15:0] b,
                                 input logic c);
    exp_t        e;
    logic [16:0] full;
    logic [15:0] low;
    if (m) begin
      full = {1'b0, a} + {1'b0, b} + {16'd0, c};
      low  = {1'b0, a[14:0]} + {1'b0, b[14:0]} + {15'd0, c};
    end else begin
      full = {1'b0, a} - {1'b0, b} - {16'd0, c};
      low  = {1'b0, a[14:0]} - {1'b0, b[14:0]} - {15'd0, c};
    end
    e.res = full[15:0];
    e.bo  = full[16];
    e.ov  = low[15] ^ full[16];
    e.cyc = 0;
    return e;
  endfunction

  // Drives at the current time; caller must be away from the rising edge.
  task automatic issue(input int w, input logic m, input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    exp_t e;
    mode = m; x = a; y = b; bin = c;
    start_v[w] = 1'b1;
    @(posedge clk);
    #1;
    start_v[w] = 1'b0;
    e     = model(m, a, b, c);
    e.cyc = cyc;
    case (w)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    check_eq("busy_after_accept", {31'd0, busy_v[w]}, 32'd1);
  endtask

  task automatic wait_done(input int w);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_v[w]) return;
    end
    check_eq("done_timeout", {31'd0, done_v[w]}, 32'd1);
  endtask

  always @(negedge clk) begin
    for (int w = 0; w < 3; w++) begin
      if (reset_n === 1'b1 && done_v[w] === 1'b1) begin
        exp_t e;
        bit   got;
        got = 1'b0;
        case (w)
          0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
          check_eq("unexpected_done", {31'd0, done_v[w]}, 32'd0);
        end else begin
          check_eq("result", {16'd0, res_v[w]}, {16'd0, e.res});
          check_eq("bout", {31'd0, bout_v[w]}, {31'd0, e.bo});
          check_eq("overflow", {31'd0, ovf_v[w]}, {31'd0, e.ov});
          check_eq("latency", cyc - e.cyc, ndig(w));
          check_eq("busy_in_done", {31'd0, busy_v[w]}, 32'd0);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    for (int w = 0; w < 3; w++) begin
      check_eq({tag, "_busy"}, {31'd0, busy_v[w]}, 32'd0);
      check_eq({tag, "_done"}, {31'd0, done_v[w]}, 32'd0);
      check_eq({tag, "_result"}, {16'd0, res_v[w]}, 32'd0);
      check_eq({tag, "_bout"}, {31'd0, bout_v[w]}, 32'd0);
      check_eq({tag, "_ovf"}, {31'd0, ovf_v[w]}, 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start_v = '0;
    mode = 1'b0; x = '0; y = '0; bin = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed cases on the DIGIT = 4 instance.
    @(negedge clk); issue(0, 1'b0, 16'h0005, 16'h0003, 1'b0); wait_done(0);
    @(negedge clk); issue(0, 1'b0, 16'h0000, 16'h0001, 1'b0); wait_done(0);
    @(negedge clk); issue(0, 1'b0, 16'h8000, 16'h0001, 1'b0); wait_done(0);
    @(negedge clk); issue(0, 1'b1, 16'h7FFF, 16'h0001, 1'b0); wait_done(0);
    @(negedge clk); issue(0, 1'b1, 16'hFFFF, 16'h0000, 1'b1); wait_done(0);
    @(negedge clk); issue(0, 1'b0, 16'h0000, 16'h0000, 1'b1); wait_done(0);

    // Start during RUN is ignored; start in the done cycle is taken at once.
    @(negedge clk); issue(0, 1'b0, 16'h1234, 16'h0034, 1'b0);
    @(negedge clk);
    mode = 1'b1; x = 16'hFFFF; y = 16'h0001; bin = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check_eq("busy_after_ignored_start", {31'd0, busy_v[0]}, 32'd1);
    wait_done(0);
    issue(0, 1'b1, 16'hABCD, 16'h1111, 1'b1);
    wait_done(0);

    // Reset pulse while digit 2 is pending: outputs clear immediately, no done.
    @(negedge clk); issue(0, 1'b1, 16'h4321, 16'h1234, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    q0.delete();
    check_zero("mid_run_reset");
    #8;
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("idle_after_abort_busy", {31'd0, busy_v[0]}, 32'd0);
    issue(0, 1'b0, 16'h0100, 16'h0001, 1'b1); wait_done(0);

    // DIGIT == WIDTH and DIGIT == 1 boundary cases.
    @(negedge clk); issue(2, 1'b1, 16'h7FFF, 16'h0001, 1'b0); wait_done(2);
    @(negedge clk); issue(1, 1'b0, 16'h8000, 16'h0001, 1'b0); wait_done(1);

    // Random regression over all three digit widths.
    for (int i = 0; i < 60; i++) begin
      int w;
      w = i % 3;
      @(negedge clk);
      issue(w, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      wait_done(w);
    end

    repeat (3) @(negedge clk);
    check_eq("queue0_drained", q0.size(), 0);
    check_eq("queue1_drained", q1.size(), 0);
    check_eq("queue2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
